// File: rtl/branch_target_buffer_pkg.sv
// Purpose: shared widths, index/tag/counter types, BTB entry payload and the
//          pc -> index / pc -> tag helpers for the branch target buffer.
package branch_target_buffer_pkg;

   localparam int unsigned ENTRY_NUM = 64;
   localparam int unsigned PC_WIDTH  = 32;
   localparam int unsigned INDEX_W   = $clog2(ENTRY_NUM);
   localparam int unsigned TAG_W     = PC_WIDTH - INDEX_W - 2;

   typedef logic [PC_WIDTH-1:0] pc_t;
   typedef logic [INDEX_W-1:0]  btb_index_t;
   typedef logic [TAG_W-1:0]    btb_tag_t;

   // 2-bit saturating direction counter; bit 1 is the taken prediction.
   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } branch_counter_e;

   // Valid bits live outside the entry so that flush/reset clear in one cycle.
   typedef struct packed {
      btb_tag_t        tag;
      pc_t             target;
      branch_counter_e ctr;
   } btb_entry_t;

   // Word-aligned PCs: bits [1:0] never take part in index or tag.
   function automatic btb_index_t to_btb_index(input pc_t pc);
      return pc[INDEX_W+1:2];
   endfunction

   function automatic btb_tag_t to_btb_tag(input pc_t pc);
      return pc[PC_WIDTH-1:INDEX_W+2];
   endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// Purpose: fetch-side lookup and MA-stage resolution bundle of the BTB.
//   lookupPc / hit / predictTaken / predictTarget : same-cycle prediction
//   updateEn / updatePc / updateTaken / updateTarget : branch resolution
//   flush : invalidate every entry on the next clock edge
// master = fetch/MA side driving requests, slave = the BTB itself.
interface branch_target_buffer_if;
   import branch_target_buffer_pkg::*;

   pc_t  lookupPc;
   logic hit;
   logic predictTaken;
   pc_t  predictTarget;

   logic updateEn;
   pc_t  updatePc;
   logic updateTaken;
   pc_t  updateTarget;

   logic flush;

   modport master (
      output lookupPc, updateEn, updatePc, updateTaken, updateTarget, flush,
      input  hit, predictTaken, predictTarget
   );

   modport slave (
      input  lookupPc, updateEn, updatePc, updateTaken, updateTarget, flush,
      output hit, predictTaken, predictTarget
   );

endinterface

// File: rtl/branch_target_buffer_counter_update.sv
// Purpose: combinational next-state of a 2-bit saturating branch counter.
//   ctr_i        : current counter
//   taken_i      : resolved direction
//   next_ctr_c_o : counter after training (saturates at STRONG_T / STRONG_NT)
module btb_counter_update
   import branch_target_buffer_pkg::*;
(
   input  branch_counter_e ctr_i,
   input  logic            taken_i,
   output branch_counter_e next_ctr_c_o
);

   // Saturating increment on taken, saturating decrement on not-taken.
   always_comb begin
      next_ctr_c_o = ctr_i;
      unique case (ctr_i)
         STRONG_NT: next_ctr_c_o = taken_i ? WEAK_NT  : STRONG_NT;
         WEAK_NT:   next_ctr_c_o = taken_i ? WEAK_T   : STRONG_NT;
         WEAK_T:    next_ctr_c_o = taken_i ? STRONG_T : WEAK_NT;
         STRONG_T:  next_ctr_c_o = taken_i ? STRONG_T : WEAK_T;
         default:   next_ctr_c_o = ctr_i;
      endcase
   end

endmodule

// File: rtl/branch_target_buffer.sv
// Purpose: direct-mapped branch target buffer with 2-bit saturating counters.
//   clk    : clock, all table updates on posedge
//   rst    : asynchronous reset, active-low
//   btb_if : slave side of branch_target_buffer_if
//            lookup is combinational from the table (no write-to-read bypass);
//            update trains/allocates on posedge; flush beats a same-cycle update.
module branch_target_buffer
   import branch_target_buffer_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   branch_target_buffer_if.slave btb_if
);

   localparam btb_entry_t ENTRY_RESET = '{tag: '0, target: '0, ctr: WEAK_NT};

   logic [ENTRY_NUM-1:0] valid_q;
   logic [ENTRY_NUM-1:0] valid_d;
   btb_entry_t           entries_q [ENTRY_NUM];

   // ---------------------------------------------------------------- lookup
   btb_index_t lk_idx;
   btb_entry_t lk_entry;
   logic       lk_hit_c;
   logic       lk_taken_c;

   assign lk_idx     = to_btb_index(btb_if.lookupPc);
   assign lk_entry   = entries_q[lk_idx];
   assign lk_hit_c   = valid_q[lk_idx] && (lk_entry.tag == to_btb_tag(btb_if.lookupPc));
   assign lk_taken_c = lk_hit_c && lk_entry.ctr[1];

   assign btb_if.hit           = lk_hit_c;
   assign btb_if.predictTaken  = lk_taken_c;
   assign btb_if.predictTarget = lk_taken_c ? lk_entry.target
                                            : PC_WIDTH'(btb_if.lookupPc + PC_WIDTH'(4));

   // ---------------------------------------------------------------- update
   btb_index_t      upd_idx;
   btb_tag_t        upd_tag;
   btb_entry_t      upd_entry;
   logic            upd_hit_c;
   branch_counter_e upd_ctr_c;
   logic            wr_en;
   btb_entry_t      wr_entry;
   logic            unused_upd_lsb;

   assign upd_idx        = to_btb_index(btb_if.updatePc);
   assign upd_tag        = to_btb_tag(btb_if.updatePc);
   assign upd_entry      = entries_q[upd_idx];
   assign upd_hit_c      = valid_q[upd_idx] && (upd_entry.tag == upd_tag);
   assign unused_upd_lsb = ^btb_if.updatePc[1:0];

   btb_counter_update u_ctr_update (
      .ctr_i        (upd_entry.ctr),
      .taken_i      (btb_if.updateTaken),
      .next_ctr_c_o (upd_ctr_c)
   );

   // Next table contents; updateTarget is only consulted on a taken branch.
   always_comb begin
      valid_d  = valid_q;
      wr_en    = 1'b0;
      wr_entry = upd_entry;
      if (btb_if.flush) begin
         valid_d = '0;
      end else if (btb_if.updateEn) begin
         if (btb_if.updateTaken) begin
            wr_en           = 1'b1;
            wr_entry.target = btb_if.updateTarget;
            if (upd_hit_c) begin
               wr_entry.ctr = upd_ctr_c;
            end else begin
               // Allocate, replacing whatever tag occupied this slot.
               wr_entry.tag     = upd_tag;
               wr_entry.ctr     = WEAK_T;
               valid_d[upd_idx] = 1'b1;
            end
         end else if (upd_hit_c) begin
            wr_en        = 1'b1;
            wr_entry.ctr = upd_ctr_c;
         end
      end
   end

   // Table storage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         for (int i = 0; i < int'(ENTRY_NUM); i++) begin
            entries_q[i] <= ENTRY_RESET;
         end
      end else begin
         valid_q <= valid_d;
         if (wr_en) begin
            entries_q[upd_idx] <= wr_entry;
         end
      end
   end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Purpose: self-checking bench for branch_target_buffer: directed scenarios with
//          literal expectations plus randomized traffic against a table model.
module tb_branch_target_buffer;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   branch_target_buffer_if bif ();

   branch_target_buffer dut (
      .clk    (clk),
      .rst    (rst),
      .btb_if (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference table: plain arrays, counter held as an integer 0..3.
   bit          m_valid [64];
   logic [31:0] m_tag   [64];
   logic [31:0] m_tgt   [64];
   int          m_ctr   [64];

   task automatic model_reset();
      for (int i = 0; i < 64; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = '0;
         m_tgt[i]   = '0;
         m_ctr[i]   = 1;
      end
   endtask

   task automatic model_lookup(input logic [31:0] pc, output logic e_hit,
                               output logic e_pt, output logic [31:0] e_tgt);
      int idx;
      idx   = int'((pc >> 2) % 64);
      e_hit = m_valid[idx] && (m_tag[idx] == (pc >> 8));
      e_pt  = e_hit && (m_ctr[idx] >= 2);
      e_tgt = e_pt ? m_tgt[idx] : pc + 32'd4;
   endtask

   task automatic model_update();
      int          idx;
      logic [31:0] t;
      bit          h;
      if (!rst) return;
      if (bif.flush) begin
         for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
         return;
      end
      if (!bif.updateEn) return;
      idx = int'((bif.updatePc >> 2) % 64);
      t   = bif.updatePc >> 8;
      h   = m_valid[idx] && (m_tag[idx] == t);
      if (bif.updateTaken) begin
         m_tgt[idx] = bif.updateTarget;
         if (h) begin
            m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
         end else begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = t;
            m_ctr[idx]   = 2;
         end
      end else if (h) begin
         m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_model();
      logic        eh;
      logic        ep;
      logic [31:0] et;
      model_lookup(bif.lookupPc, eh, ep, et);
      chk("model hit", 32'(bif.hit), 32'(eh));
      chk("model predictTaken", 32'(bif.predictTaken), 32'(ep));
      chk("model predictTarget", bif.predictTarget, et);
   endtask

   // One cycle: compare against the model at negedge, train the model at posedge.
   task automatic tick();
      @(negedge clk);
      cmp_model();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic expect3(input string name, input logic e_hit, input logic e_pt,
                          input logic [31:0] e_tgt);
      #1;
      chk({name, " hit"}, 32'(bif.hit), 32'(e_hit));
      chk({name, " predictTaken"}, 32'(bif.predictTaken), 32'(e_pt));
      chk({name, " predictTarget"}, bif.predictTarget, e_tgt);
   endtask

   task automatic set_upd(input logic en, input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt);
      bif.updateEn     = en;
      bif.updatePc     = pc;
      bif.updateTaken  = tk;
      bif.updateTarget = tgt;
   endtask

   task automatic rand_pc(output logic [31:0] pc);
      logic [31:0] tagv;
      tagv = ($urandom_range(0, 15) == 0) ? 32'h00FF_FFFF : 32'($urandom_range(0, 3));
      pc   = (tagv << 8) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
   endtask

   initial begin
      logic [31:0] pc;
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      bif.lookupPc = 32'h100;
      bif.flush    = 1'b0;
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      model_reset();
      #2 rst = 1'b0;
      model_reset();

      // Cold lookup, during and after reset.
      expect3("cold_in_rst", 1'b0, 1'b0, 32'h104);
      tick();
      rst = 1'b1;
      expect3("cold", 1'b0, 1'b0, 32'h104);

      // Allocate on a taken miss.
      set_upd(1'b1, 32'h100, 1'b1, 32'h200);
      tick();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      expect3("alloc", 1'b1, 1'b1, 32'h200);

      // Saturation up, then walk down to strongly not-taken.
      set_upd(1'b1, 32'h100, 1'b1, 32'h200);
      tick();
      tick();
      set_upd(1'b1, 32'h100, 1'b0, 32'h0);
      tick();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      expect3("sat_nt1", 1'b1, 1'b1, 32'h200);
      set_upd(1'b1, 32'h100, 1'b0, 32'h0);
      tick();
      tick();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      expect3("sat_nt3", 1'b1, 1'b0, 32'h104);

      // Conflict replacement at index 0.
      set_upd(1'b1, 32'h100, 1'b1, 32'h200);
      tick();
      set_upd(1'b1, 32'h200, 1'b1, 32'h300);
      tick();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      expect3("conf_old", 1'b0, 1'b0, 32'h104);
      bif.lookupPc = 32'h200;
      expect3("conf_new", 1'b1, 1'b1, 32'h300);

      // Same-cycle update and lookup: old contents first, new contents next cycle.
      set_upd(1'b1, 32'h100, 1'b1, 32'h500);
      tick();
      bif.lookupPc = 32'h100;
      set_upd(1'b1, 32'h100, 1'b0, 32'h0);
      expect3("same_cyc_old", 1'b1, 1'b1, 32'h500);
      tick();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      expect3("same_cyc_new", 1'b1, 1'b0, 32'h104);

      // Not-taken miss never allocates.
      set_upd(1'b1, 32'h180, 1'b0, 32'h777);
      tick();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      bif.lookupPc = 32'h180;
      expect3("nt_miss", 1'b0, 1'b0, 32'h184);

      // Flush beats a simultaneous update; the flush cycle still sees old contents.
      bif.lookupPc = 32'h100;
      bif.flush    = 1'b1;
      set_upd(1'b1, 32'h180, 1'b1, 32'h900);
      expect3("flush_cyc", 1'b1, 1'b0, 32'h104);
      tick();
      bif.flush = 1'b0;
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      expect3("post_flush_a", 1'b0, 1'b0, 32'h104);
      bif.lookupPc = 32'h180;
      expect3("post_flush_b", 1'b0, 1'b0, 32'h184);

      // Fall-through target wraps.
      bif.lookupPc = 32'hFFFF_FFFC;
      expect3("wrap", 1'b0, 1'b0, 32'h0);

      // Asynchronous reset between clock edges clears hits immediately.
      set_upd(1'b1, 32'h40, 1'b1, 32'h80);
      tick();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      bif.lookupPc = 32'h40;
      expect3("pre_rst", 1'b1, 1'b1, 32'h80);
      #1 rst = 1'b0;
      model_reset();
      expect3("async_rst", 1'b0, 1'b0, 32'h44);
      tick();
      rst = 1'b1;
      expect3("post_rst", 1'b0, 1'b0, 32'h44);

      // Randomized traffic over a small set of indices and tags.
      for (int n = 0; n < 800; n++) begin
         rand_pc(pc);
         bif.lookupPc = pc;
         rand_pc(pc);
         set_upd(($urandom_range(0, 3) != 0), pc, ($urandom_range(0, 2) != 0), $urandom);
         bif.flush = ($urandom_range(0, 49) == 0);
         tick();
      end
      bif.flush = 1'b0;
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
